// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings, port ids and default widths for the data-memory arbiter
`ifndef REG_LEN
`define REG_LEN 32
`endif
`ifndef DM_UNIT
`define DM_UNIT 256
`endif
package dmem_arbiter_pkg;
  localparam int ADDR_W_DEF = `REG_LEN;
  localparam int LINE_W_DEF = `DM_UNIT;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic PORT_DCACHE = 1'b0;
  localparam logic PORT_ICACHE = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: two-way picker, on contention the port that was not granted last (ptr) wins
module dmem_arb_pick (
  input  logic en0,
  input  logic en1,
  input  logic ptr,
  output logic win,
  output logic valid
);
  assign valid = en0 | en1;
  assign win = (en0 & en1) ? ~ptr : en1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one line-wide memory port between dcache (0) and icache (1), round-robin when DMEM_ARB_RR_EN is defined
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [LINE_W-1:0] rsp_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o
);
  logic [1:0] state;
  logic win, valid, ptr;
  dmem_arb_pick u_pick (
    .en0  (req0_enable_i),
    .en1  (req1_enable_i),
    .ptr  (ptr),
    .win  (win),
    .valid(valid)
  );
`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk_i)
    ptr <= rst_i ? PORT_DCACHE : (state == ST_IDLE && valid) ? win : ptr;
`else
  assign ptr = PORT_ICACHE;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      req0_ack_o   <= 1'b0;
      req1_ack_o   <= 1'b0;
      grant_o      <= PORT_DCACHE;
      rsp_data_o   <= '0;
    end else if (state == ST_IDLE) begin
      if (valid) begin
        state        <= ST_BUSY;
        mem_enable_o <= 1'b1;
        mem_write_o  <= win ? req1_write_i : req0_write_i;
        mem_addr_o   <= win ? req1_addr_i : req0_addr_i;
        mem_data_o   <= win ? req1_data_i : req0_data_i;
        grant_o      <= win;
      end
    end else if (state == ST_BUSY) begin
      if (mem_ack_i) begin
        state        <= ST_DONE;
        mem_enable_o <= 1'b0;
        mem_write_o  <= 1'b0;
        req0_ack_o   <= grant_o == PORT_DCACHE;
        req1_ack_o   <= grant_o == PORT_ICACHE;
        rsp_data_o   <= mem_data_i;
      end
    end else begin
      state      <= ST_IDLE;
      req0_ack_o <= 1'b0;
      req1_ack_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a fixed-latency memory model
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int ACK_LAT = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit FIRST = 1'b1;
`else
  localparam bit FIRST = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_i;
  logic req0_enable_i, req0_write_i, req1_enable_i, req1_write_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [LW-1:0] req0_data_i, req1_data_i;
  logic req0_ack_o, req1_ack_o;
  logic [LW-1:0] rsp_data_o, mem_data_o, mem_data_i;
  logic mem_enable_o, mem_write_o, mem_ack_i, grant_o;
  logic [AW-1:0] mem_addr_o;
  typedef struct {bit port; bit wr; logic [AW-1:0] addr; logic [LW-1:0] data;} bus_t;
  typedef struct {bit port; logic [LW-1:0] rsp;} ack_t;
  typedef struct {int id; logic [LW-1:0] exp;} probe_t;
  bus_t bus_q[$];
  ack_t ack_q[$];
  probe_t probe_q[$];
  int checks = 0;
  int failures = 0;
  int to_cnt = 0;
  bit done = 1'b0;
  bit mem_auto = 1'b1;
  bit man_ack = 1'b0;
  localparam logic [LW-1:0] D0 = {8{32'h1111_0000}};
  localparam logic [LW-1:0] D1 = {8{32'h2222_0001}};
  localparam logic [LW-1:0] D2 = {8{32'h3333_0002}};
  localparam logic [LW-1:0] D3 = {8{32'h4444_0003}};
  localparam logic [LW-1:0] D4 = {8{32'h5555_0004}};
  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i), .req0_addr_i(req0_addr_i),
    .req0_data_i(req0_data_i), .req0_ack_o(req0_ack_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i), .req1_addr_i(req1_addr_i),
    .req1_data_i(req1_data_i), .req1_ack_o(req1_ack_o),
    .rsp_data_o(rsp_data_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .grant_o(grant_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [LW-1:0] rd_line(input logic [AW-1:0] a);
    return (a == 32'h400) ? {32{8'hA5}} : {8{a ^ 32'h5A5A_0000}};
  endfunction
  function automatic string pname(input int id);
    case (id)
      0: return "mem_enable_o";
      1: return "mem_write_o";
      2: return "mem_addr_o";
      3: return "mem_data_o";
      4: return "req0_ack_o";
      5: return "req1_ack_o";
      6: return "grant_o";
      default: return "rsp_data_o";
    endcase
  endfunction
  function automatic logic [LW-1:0] pval(input int id);
    case (id)
      0: return LW'(mem_enable_o);
      1: return LW'(mem_write_o);
      2: return LW'(mem_addr_o);
      3: return mem_data_o;
      4: return LW'(req0_ack_o);
      5: return LW'(req1_ack_o);
      6: return LW'(grant_o);
      default: return rsp_data_o;
    endcase
  endfunction
  function automatic void chk(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endfunction
  // memory model: acks ACK_LAT cycles after the request rises, or follows man_ack in manual mode
  initial begin
    int lat;
    lat = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!mem_auto) begin
        mem_ack_i = man_ack;
        lat = 0;
      end else if (mem_enable_o && !mem_ack_i) begin
        lat++;
        if (lat == ACK_LAT) begin
          mem_ack_i = 1'b1;
          mem_data_i = rd_line(mem_addr_o);
          lat = 0;
        end
      end else begin
        mem_ack_i = 1'b0;
        lat = 0;
      end
    end
  end
  // monitor: owns all comparisons; probes, bus transactions and acks against the scoreboard queues
  initial begin
    bit en_q, ack_prev;
    logic [AW+LW:0] held;
    probe_t p;
    bus_t b;
    ack_t a;
    en_q = 1'b0;
    ack_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_i);
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        chk(pname(p.id), pval(p.id), p.exp);
      end
      if (mem_enable_o && !en_q) begin
        if (bus_q.size() == 0) chk("unexpected_bus_req", 1, 0);
        else begin
          b = bus_q.pop_front();
          chk("bus_grant", LW'(grant_o), LW'(b.port));
          chk("bus_write", LW'(mem_write_o), LW'(b.wr));
          chk("bus_addr", LW'(mem_addr_o), LW'(b.addr));
          chk("bus_data", mem_data_o, b.data);
        end
        held = {mem_write_o, mem_addr_o, mem_data_o};
      end else if (mem_enable_o) begin
        chk("bus_hold", LW'({mem_write_o, mem_addr_o, mem_data_o} != held), 0);
      end
      en_q = mem_enable_o;
      if (req0_ack_o && req1_ack_o) chk("ack_both", 1, 0);
      if (req0_ack_o || req1_ack_o) begin
        if (ack_prev) chk("ack_width", 1, 0);
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = ack_q.pop_front();
          chk("ack_port", LW'(req1_ack_o), LW'(a.port));
          chk("ack_rsp", rsp_data_o, a.rsp);
        end
      end
      ack_prev = req0_ack_o || req1_ack_o;
      if (done) begin
        chk("bus_q_left", LW'(bus_q.size()), 0);
        chk("ack_q_left", LW'(ack_q.size()), 0);
        chk("wait_timeouts", LW'(to_cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic probe(input int id, input logic [LW-1:0] e);
    probe_q.push_back('{id, e});
  endtask
  task automatic push_bus(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] data);
    bus_q.push_back('{port, wr, addr, data});
  endtask
  task automatic expect_txn(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] data);
    push_bus(port, wr, addr, data);
    ack_q.push_back('{port, rd_line(addr)});
  endtask
  task automatic wait_ack(input bit port, input bit drop);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(port ? req1_ack_o : req0_ack_o) && n < 100);
    if (n >= 100) to_cnt++;
    if (drop && port) req1_enable_i = 1'b0;
    if (drop && !port) req0_enable_i = 1'b0;
  endtask
  task automatic do_reset(input int n);
    rst_i = 1'b1;
    repeat (n) tick();
    rst_i = 1'b0;
  endtask
  initial begin
    rst_i = 1'b1;
    {req0_enable_i, req0_write_i, req1_enable_i, req1_write_i} = '0;
    req0_addr_i = '0; req1_addr_i = '0; req0_data_i = '0; req1_data_i = '0;
    do_reset(3);
    rst_i = 1'b1;
    for (int i = 0; i < 8; i++) probe(i, '0);
    rst_i = 1'b0;
    repeat (3) tick();
    probe(0, 0);
    req1_enable_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h400; req1_data_i = D1;
    expect_txn(1, 0, 32'h400, D1);
    tick();
    probe(0, 1);
    wait_ack(1, 1);
    probe(4, 0);
    repeat (3) tick();
    probe(7, {32{8'hA5}});
    do_reset(1);
    for (int r = 0; r < 2; r++) begin
      req0_enable_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h100; req0_data_i = D0;
      req1_enable_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h200; req1_data_i = D1;
      if (FIRST) expect_txn(1, 0, 32'h200, D1); else expect_txn(0, 1, 32'h100, D0);
      if (FIRST) expect_txn(0, 1, 32'h100, D0); else expect_txn(1, 0, 32'h200, D1);
      wait_ack(FIRST, 1);
      probe(0, 0);
      tick();
      probe(0, 0);
      tick();
      probe(0, 1);
      wait_ack(!FIRST, 1);
    end
    do_reset(1);
    req0_enable_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h300; req0_data_i = D2;
    expect_txn(0, 1, 32'h300, D2);
`ifdef DMEM_ARB_RR_EN
    expect_txn(1, 0, 32'h900, D3);
    expect_txn(0, 0, 32'h700, D2);
`else
    expect_txn(0, 0, 32'h700, D2);
    expect_txn(1, 0, 32'h900, D3);
`endif
    tick();
    req1_enable_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h900; req1_data_i = D3;
    wait_ack(0, 0);
    req0_write_i = 1'b0; req0_addr_i = 32'h700;
`ifdef DMEM_ARB_RR_EN
    wait_ack(1, 1);
    wait_ack(0, 1);
`else
    wait_ack(0, 1);
    wait_ack(1, 1);
`endif
    do_reset(1);
    mem_auto = 1'b0;
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h500; req0_data_i = D4;
    push_bus(0, 0, 32'h500, D4);
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    probe(0, 0);
    rst_i = 1'b0;
    req0_enable_i = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    repeat (4) begin
      tick();
      probe(0, 0);
      probe(4, 0);
      probe(5, 0);
    end
    mem_auto = 1'b1;
    tick();
    done = 1'b1;
  end
endmodule
